// File: rtl/cell_link_pkg.sv
// cell_link_pkg: shared widths and arbiter state encoding for the cell-link merge path
package cell_link_pkg;
  localparam int CELL_LINK_DATA_WIDTH = 32;
  localparam int DROP_COUNT_WIDTH = 16;
  typedef enum logic [1:0] {ARB_IDLE, ARB_SEND0, ARB_SEND1} arbState_t;
endpackage

// File: rtl/cell_link_packet_fifo.sv
// cell_link_packet_fifo: packet-mode FIFO exposing only committed packets, with overflow drop accounting
module cell_link_packet_fifo import cell_link_pkg::*; #(
  parameter int DATA_WIDTH = CELL_LINK_DATA_WIDTH,
  parameter int FIFO_DEPTH = 256,
  parameter dbg = "false"
) (
  input  logic                        auroraUserClk,
  input  logic                        auroraResetN,
  input  logic                        auroraFAstrobe,
  input  logic                        sTVALID,
  input  logic                        sTLAST,
  input  logic [DATA_WIDTH-1:0]       sTDATA,
  input  logic                        rdPop,
  output logic [DATA_WIDTH-1:0]       headData,
  output logic                        headLast,
  output logic                        pktAvail,
  output logic [DROP_COUNT_WIDTH-1:0] dropCount
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
  (* mark_debug = dbg *) logic [AW:0] wrTent, wrCommit, rdPtr, pktCount;
  (* mark_debug = dbg *) logic discard;
  logic [AW:0] rdNext;
  logic full, wrBeat, commit, lastPop;
  assign full = wrTent[AW] != rdPtr[AW] && wrTent[AW-1:0] == rdPtr[AW-1:0];
  assign wrBeat = auroraResetN && !auroraFAstrobe && sTVALID && !discard && !full;
  assign commit = wrBeat && sTLAST;
  assign lastPop = rdPop && headLast;
  assign rdNext = rdPop ? rdPtr + 1 : rdPtr;
  assign pktAvail = pktCount != '0;
  always_ff @(posedge auroraUserClk)
    if (wrBeat) mem[wrTent[AW-1:0]] <= {sTLAST, sTDATA};
  always_ff @(posedge auroraUserClk)
    {headLast, headData} <= mem[rdNext[AW-1:0]];
  always_ff @(posedge auroraUserClk) begin
    if (!auroraResetN) begin
      wrTent <= '0;
      wrCommit <= '0;
      rdPtr <= '0;
      pktCount <= '0;
      discard <= 1'b0;
      dropCount <= '0;
    end else if (auroraFAstrobe) begin
      wrTent <= '0;
      wrCommit <= '0;
      rdPtr <= '0;
      pktCount <= '0;
      discard <= discard || wrTent != wrCommit;
    end else begin
      rdPtr <= rdNext;
      pktCount <= commit && !lastPop ? pktCount + 1 : !commit && lastPop ? pktCount - 1 : pktCount;
      if (sTVALID) begin
        if (discard) discard <= !sTLAST;
        else if (full) begin
          wrTent <= wrCommit;
          discard <= !sTLAST;
          dropCount <= dropCount != '1 ? dropCount + 1 : dropCount;
        end else begin
          wrTent <= wrTent + 1;
          if (sTLAST) wrCommit <= wrTent + 1;
        end
      end
    end
  end
endmodule

// File: rtl/cell_link_merge_arbiter.sv
// cell_link_merge_arbiter: round-robin packet-atomic merge of cell-link RX and local streams
module cell_link_merge_arbiter import cell_link_pkg::*; #(
  parameter int DATA_WIDTH = CELL_LINK_DATA_WIDTH,
  parameter int FIFO_DEPTH = 256,
  parameter dbg = "false"
) (
  input  logic                        auroraUserClk,
  input  logic                        auroraResetN,
  input  logic                        auroraFAstrobe,
  input  logic                        s0TVALID,
  input  logic                        s0TLAST,
  input  logic [DATA_WIDTH-1:0]       s0TDATA,
  input  logic                        s1TVALID,
  input  logic                        s1TLAST,
  input  logic [DATA_WIDTH-1:0]       s1TDATA,
  output logic                        mTVALID,
  output logic                        mTLAST,
  output logic [DATA_WIDTH-1:0]       mTDATA,
  input  logic                        mTREADY,
  output logic                        mSource,
  output logic [DROP_COUNT_WIDTH-1:0] s0DropCount,
  output logic [DROP_COUNT_WIDTH-1:0] s1DropCount
);
  (* mark_debug = dbg *) arbState_t state;
  (* mark_debug = dbg *) logic last;
  logic [DATA_WIDTH-1:0] headData0, headData1;
  logic headLast0, headLast1, avail0, avail1, pop0, pop1, grant;
  assign pop0 = mTVALID && mTREADY && !mSource;
  assign pop1 = mTVALID && mTREADY && mSource;
  assign grant = avail0 && avail1 ? !last : avail1;
  assign mTDATA = !mTVALID ? '0 : mSource ? headData1 : headData0;
  assign mTLAST = mTVALID && (mSource ? headLast1 : headLast0);
  cell_link_packet_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .dbg(dbg)) fifo0 (
    .auroraUserClk(auroraUserClk), .auroraResetN(auroraResetN), .auroraFAstrobe(auroraFAstrobe),
    .sTVALID(s0TVALID), .sTLAST(s0TLAST), .sTDATA(s0TDATA), .rdPop(pop0),
    .headData(headData0), .headLast(headLast0), .pktAvail(avail0), .dropCount(s0DropCount)
  );
  cell_link_packet_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .dbg(dbg)) fifo1 (
    .auroraUserClk(auroraUserClk), .auroraResetN(auroraResetN), .auroraFAstrobe(auroraFAstrobe),
    .sTVALID(s1TVALID), .sTLAST(s1TLAST), .sTDATA(s1TDATA), .rdPop(pop1),
    .headData(headData1), .headLast(headLast1), .pktAvail(avail1), .dropCount(s1DropCount)
  );
  always_ff @(posedge auroraUserClk) begin
    if (!auroraResetN) begin
      state <= ARB_IDLE;
      mTVALID <= 1'b0;
      mSource <= 1'b0;
      last <= 1'b1;
    end else if (auroraFAstrobe) begin
      state <= ARB_IDLE;
      mTVALID <= 1'b0;
    end else if (state == ARB_IDLE) begin
      if (avail0 || avail1) begin
        state <= grant ? ARB_SEND1 : ARB_SEND0;
        mTVALID <= 1'b1;
        mSource <= grant;
      end
    end else if (mTREADY && mTLAST) begin
      state <= ARB_IDLE;
      mTVALID <= 1'b0;
      last <= mSource;
    end
  end
endmodule

// File: tb/tb_cell_link_merge_arbiter.sv
// tb_cell_link_merge_arbiter: directed scenarios for the cell-link merge arbiter
module tb_cell_link_merge_arbiter;
  logic auroraUserClk = 1'b0;
  logic auroraResetN, auroraFAstrobe, s0TVALID, s0TLAST, s1TVALID, s1TLAST, mTREADY;
  logic [31:0] s0TDATA, s1TDATA, mTDATA;
  logic mTVALID, mTLAST, mSource;
  logic [15:0] s0DropCount, s1DropCount;
  typedef struct {
    logic [31:0] data;
    logic last;
    logic src;
    int cyc;
  } beat_t;
  beat_t got[$];
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  cell_link_merge_arbiter #(.DATA_WIDTH(32), .FIFO_DEPTH(16), .dbg("false")) dut (
    .auroraUserClk(auroraUserClk), .auroraResetN(auroraResetN), .auroraFAstrobe(auroraFAstrobe),
    .s0TVALID(s0TVALID), .s0TLAST(s0TLAST), .s0TDATA(s0TDATA),
    .s1TVALID(s1TVALID), .s1TLAST(s1TLAST), .s1TDATA(s1TDATA),
    .mTVALID(mTVALID), .mTLAST(mTLAST), .mTDATA(mTDATA), .mTREADY(mTREADY),
    .mSource(mSource), .s0DropCount(s0DropCount), .s1DropCount(s1DropCount)
  );

  always #5 auroraUserClk = ~auroraUserClk;
  always @(posedge auroraUserClk) cyc <= cyc + 1;
  always @(negedge auroraUserClk) if (mTVALID && mTREADY) got.push_back('{mTDATA, mTLAST, mSource, cyc});

  task automatic tick();
    @(posedge auroraUserClk);
    #1;
  endtask

  task automatic step(input logic v0, input logic l0, input logic [31:0] d0,
                      input logic v1, input logic l1, input logic [31:0] d1);
    s0TVALID = v0; s0TLAST = l0; s0TDATA = d0;
    s1TVALID = v1; s1TLAST = l1; s1TDATA = d1;
    tick();
    s0TVALID = 1'b0; s0TLAST = 1'b0; s1TVALID = 1'b0; s1TLAST = 1'b0;
  endtask

  task automatic sendPkt(input logic src, input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) step(!src, i == n - 1, base + i, src, i == n - 1, base + i);
  endtask

  task automatic sendBoth(input logic [31:0] base0, input logic [31:0] base1, input int n);
    for (int i = 0; i < n; i++) step(1'b1, i == n - 1, base0 + i, 1'b1, i == n - 1, base1 + i);
  endtask

  task automatic waitBeats(input int n, input int budget);
    while (got.size() < n && budget > 0) begin
      tick();
      budget--;
    end
  endtask

  task automatic test_reset();
    auroraResetN = 1'b0;
    repeat (3) tick();
    vectors++; if (mTVALID !== 1'b0) begin miscompares++; $display("FAIL reset_mTVALID got %b want 0", mTVALID); end
    vectors++; if (mTLAST !== 1'b0) begin miscompares++; $display("FAIL reset_mTLAST got %b want 0", mTLAST); end
    vectors++; if (mTDATA !== 32'h0) begin miscompares++; $display("FAIL reset_mTDATA got %h want 0", mTDATA); end
    vectors++; if (mSource !== 1'b0) begin miscompares++; $display("FAIL reset_mSource got %b want 0", mSource); end
    vectors++; if (s0DropCount !== 16'h0 || s1DropCount !== 16'h0) begin
      miscompares++; $display("FAIL reset_drops got %h/%h want 0/0", s0DropCount, s1DropCount);
    end
    auroraResetN = 1'b1;
    repeat (3) tick();
    vectors++; if (mTVALID !== 1'b0) begin miscompares++; $display("FAIL idle_mTVALID got %b want 0", mTVALID); end
  endtask

  task automatic test_single_packet();
    int tl;
    got.delete();
    mTREADY = 1'b1;
    sendPkt(1'b1, 32'hA5BE0400, 4);
    tl = cyc;
    vectors++; if (mTVALID !== 1'b0) begin miscompares++; $display("FAIL single_n1_valid got %b want 0", mTVALID); end
    tick();
    vectors++; if (mTVALID !== 1'b1 || mTDATA !== 32'hA5BE0400 || mSource !== 1'b1) begin
      miscompares++; $display("FAIL single_n2_header got v=%b d=%h s=%b want v=1 d=a5be0400 s=1", mTVALID, mTDATA, mSource);
    end
    waitBeats(4, 20);
    repeat (3) tick();
    vectors++; if (got.size() !== 4) begin miscompares++; $display("FAIL single_count got %0d want 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i >= got.size() || got[i].data !== 32'hA5BE0400 + i || got[i].last !== (i == 3) ||
          got[i].src !== 1'b1 || got[i].cyc !== tl + 1 + i) begin
        miscompares++;
        if (i < got.size()) $display("FAIL single_word%0d got d=%h l=%b s=%b c=%0d want d=%h l=%b s=1 c=%0d",
          i, got[i].data, got[i].last, got[i].src, got[i].cyc, 32'hA5BE0400 + i, i == 3, tl + 1 + i);
        else $display("FAIL single_word%0d got missing want d=%h", i, 32'hA5BE0400 + i);
      end
    end
  endtask

  task automatic test_tie();
    int tl;
    logic [31:0] ed;
    logic es;
    got.delete();
    mTREADY = 1'b1;
    sendBoth(32'h0A000000, 32'h1A000000, 3);
    tl = cyc;
    waitBeats(6, 40);
    repeat (2) tick();
    vectors++; if (got.size() !== 6) begin miscompares++; $display("FAIL tie1_count got %0d want 6", got.size()); end
    for (int i = 0; i < 6; i++) begin
      es = i >= 3;
      ed = es ? 32'h1A000000 + i - 3 : 32'h0A000000 + i;
      vectors++;
      if (i >= got.size() || got[i].data !== ed || got[i].src !== es || got[i].last !== (i % 3 == 2) ||
          got[i].cyc !== tl + 1 + i + int'(es)) begin
        miscompares++;
        if (i < got.size()) $display("FAIL tie1_word%0d got d=%h s=%b c=%0d want d=%h s=%b c=%0d",
          i, got[i].data, got[i].src, got[i].cyc, ed, es, tl + 1 + i + int'(es));
        else $display("FAIL tie1_word%0d got missing want d=%h", i, ed);
      end
    end
    got.delete();
    sendPkt(1'b0, 32'h2A000000, 2);
    waitBeats(2, 20);
    repeat (2) tick();
    got.delete();
    sendBoth(32'h3A000000, 32'h4A000000, 3);
    tl = cyc;
    waitBeats(6, 40);
    repeat (2) tick();
    vectors++; if (got.size() !== 6) begin miscompares++; $display("FAIL tie2_count got %0d want 6", got.size()); end
    for (int i = 0; i < 6; i++) begin
      es = i < 3;
      ed = es ? 32'h4A000000 + i : 32'h3A000000 + i - 3;
      vectors++;
      if (i >= got.size() || got[i].data !== ed || got[i].src !== es || got[i].last !== (i % 3 == 2) ||
          got[i].cyc !== tl + 1 + i + int'(!es)) begin
        miscompares++;
        if (i < got.size()) $display("FAIL tie2_word%0d got d=%h s=%b c=%0d want d=%h s=%b c=%0d",
          i, got[i].data, got[i].src, got[i].cyc, ed, es, tl + 1 + i + int'(!es));
        else $display("FAIL tie2_word%0d got missing want d=%h", i, ed);
      end
    end
  endtask

  task automatic test_overflow();
    got.delete();
    mTREADY = 1'b0;
    sendPkt(1'b0, 32'h50000000, 20);
    repeat (4) tick();
    vectors++; if (mTVALID !== 1'b0) begin miscompares++; $display("FAIL ovf_no_valid got %b want 0", mTVALID); end
    vectors++; if (s0DropCount !== 16'd1) begin miscompares++; $display("FAIL ovf_s0drop got %0d want 1", s0DropCount); end
    vectors++; if (s1DropCount !== 16'd0) begin miscompares++; $display("FAIL ovf_s1drop got %0d want 0", s1DropCount); end
    sendPkt(1'b0, 32'h60000000, 2);
    repeat (3) tick();
    vectors++; if (mTVALID !== 1'b1 || mTDATA !== 32'h60000000) begin
      miscompares++; $display("FAIL ovf_stalled_head got v=%b d=%h want v=1 d=60000000", mTVALID, mTDATA);
    end
    mTREADY = 1'b1;
    waitBeats(2, 20);
    repeat (2) tick();
    vectors++; if (got.size() !== 2) begin miscompares++; $display("FAIL ovf_after_count got %0d want 2", got.size()); end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (i >= got.size() || got[i].data !== 32'h60000000 + i || got[i].last !== (i == 1) || got[i].src !== 1'b0) begin
        miscompares++; $display("FAIL ovf_after_word%0d want d=%h l=%b", i, 32'h60000000 + i, i == 1);
      end
    end
  endtask

  task automatic test_backpressure();
    int rp[10] = '{1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    int budget = 20;
    logic prevStall = 1'b0;
    logic prevLast;
    logic [31:0] prevData;
    got.delete();
    mTREADY = 1'b0;
    sendPkt(1'b0, 32'h70000000, 5);
    while (!mTVALID && budget > 0) begin tick(); budget--; end
    vectors++; if (mTVALID !== 1'b1) begin miscompares++; $display("FAIL bp_grant got %b want 1", mTVALID); end
    for (int i = 0; i < 10; i++) begin
      if (prevStall) begin
        vectors++;
        if (mTVALID !== 1'b1 || mTDATA !== prevData || mTLAST !== prevLast) begin
          miscompares++; $display("FAIL bp_hold%0d got v=%b d=%h l=%b want v=1 d=%h l=%b", i, mTVALID, mTDATA, mTLAST, prevData, prevLast);
        end
      end
      mTREADY = rp[i] != 0;
      if (!mTREADY) begin
        vectors++;
        if (mTDATA !== 32'h70000001) begin miscompares++; $display("FAIL bp_stall_data%0d got %h want 70000001", i, mTDATA); end
      end
      prevStall = mTVALID && !mTREADY;
      prevData = mTDATA;
      prevLast = mTLAST;
      tick();
    end
    mTREADY = 1'b1;
    repeat (2) tick();
    vectors++; if (got.size() !== 5) begin miscompares++; $display("FAIL bp_count got %0d want 5", got.size()); end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (i >= got.size() || got[i].data !== 32'h70000000 + i || got[i].last !== (i == 4)) begin
        miscompares++; $display("FAIL bp_word%0d want d=%h l=%b", i, 32'h70000000 + i, i == 4);
      end
    end
  endtask

  task automatic test_strobe();
    int tl;
    got.delete();
    mTREADY = 1'b0;
    sendPkt(1'b1, 32'h80000000, 2);
    repeat (3) tick();
    vectors++; if (mTVALID !== 1'b1 || mSource !== 1'b1) begin
      miscompares++; $display("FAIL fa_pending got v=%b s=%b want v=1 s=1", mTVALID, mSource);
    end
    step(1'b1, 1'b0, 32'h90000000, 1'b0, 1'b0, 32'h0);
    auroraFAstrobe = 1'b1;
    step(1'b1, 1'b0, 32'h90000001, 1'b0, 1'b0, 32'h0);
    auroraFAstrobe = 1'b0;
    vectors++; if (mTVALID !== 1'b0) begin miscompares++; $display("FAIL fa_valid_drop got %b want 0", mTVALID); end
    mTREADY = 1'b1;
    for (int i = 2; i < 6; i++) step(1'b1, i == 5, 32'h90000000 + i, 1'b0, 1'b0, 32'h0);
    repeat (6) tick();
    vectors++; if (got.size() !== 0) begin miscompares++; $display("FAIL fa_flushed got %0d beats want 0", got.size()); end
    vectors++; if (s0DropCount !== 16'd1 || s1DropCount !== 16'd0) begin
      miscompares++; $display("FAIL fa_drops_kept got %0d/%0d want 1/0", s0DropCount, s1DropCount);
    end
    sendPkt(1'b0, 32'hA0000000, 3);
    tl = cyc;
    waitBeats(3, 20);
    repeat (2) tick();
    vectors++; if (got.size() !== 3) begin miscompares++; $display("FAIL fa_next_count got %0d want 3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (i >= got.size() || got[i].data !== 32'hA0000000 + i || got[i].last !== (i == 2) ||
          got[i].src !== 1'b0 || got[i].cyc !== tl + 1 + i) begin
        miscompares++; $display("FAIL fa_next_word%0d want d=%h l=%b c=%0d", i, 32'hA0000000 + i, i == 2, tl + 1 + i);
      end
    end
  endtask

  task automatic test_reset_mid();
    got.delete();
    mTREADY = 1'b0;
    sendPkt(1'b0, 32'hB0000000, 3);
    repeat (3) tick();
    vectors++; if (mTVALID !== 1'b1 || mSource !== 1'b0) begin
      miscompares++; $display("FAIL rst_send0 got v=%b s=%b want v=1 s=0", mTVALID, mSource);
    end
    auroraResetN = 1'b0;
    tick();
    vectors++; if (mTVALID !== 1'b0 || mTLAST !== 1'b0 || mTDATA !== 32'h0) begin
      miscompares++; $display("FAIL rst_outputs got v=%b l=%b d=%h want 0/0/0", mTVALID, mTLAST, mTDATA);
    end
    vectors++; if (s0DropCount !== 16'd0 || s1DropCount !== 16'd0) begin
      miscompares++; $display("FAIL rst_drops got %0d/%0d want 0/0", s0DropCount, s1DropCount);
    end
    auroraResetN = 1'b1;
    mTREADY = 1'b1;
    repeat (5) tick();
    vectors++; if (got.size() !== 0) begin miscompares++; $display("FAIL rst_flushed got %0d beats want 0", got.size()); end
  endtask

  initial begin
    auroraResetN = 1'b0; auroraFAstrobe = 1'b0; mTREADY = 1'b0;
    s0TVALID = 1'b0; s0TLAST = 1'b0; s0TDATA = '0;
    s1TVALID = 1'b0; s1TLAST = 1'b0; s1TDATA = '0;
    test_reset();
    test_single_packet();
    test_tie();
    test_overflow();
    test_backpressure();
    test_strobe();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cell_link_merge_arbiter.md
# cell_link_merge_arbiter

- Merges the incoming cell-link receive stream and the local cell stream into one packet-atomic stream for the cell-link forwarder.
- Each input is buffered in its own packet-mode FIFO, and only whole packets are offered downstream.
- A round-robin arbiter grants the output one complete packet at a time.
- This replaces the vendor AXI-stream switch, adding drop accounting and explicit flush on the FA strobe.

## Interface
- `DATA_WIDTH`, default 32: stream word width.
- `FIFO_DEPTH`, default 256: per-input buffer capacity in words; must be a power of two, at least 16.
- `dbg`, default "false": mark_debug attribute value for internal state.
- `auroraUserClk`, in, 1: sole clock.
- `auroraResetN`, in, 1: reset, synchronous and active-low.
- `auroraFAstrobe`, in, 1: one-cycle flush at start of each FA interval.
- `s0TVALID`, `s0TLAST`, in, 1 each: cell-link RX stream. There is no TREADY; the source cannot stall.
- `s0TDATA`, in, `DATA_WIDTH`: cell-link RX data.
- `s1TVALID`, `s1TLAST`, in, 1 each: local stream. There is no TREADY.
- `s1TDATA`, in, `DATA_WIDTH`: local data.
- `mTVALID`, `mTLAST`, out, 1 each: merged output.
- `mTDATA`, out, `DATA_WIDTH`: merged data.
- `mTREADY`, in, 1: downstream ready.
- `mSource`, out, 1: input index of the packet currently on the output.
- `s0DropCount`, `s1DropCount`, out, 16: packets dropped per input; saturating.

## Operation
- **Write side, per input**
  - A beat is written when TVALID is high.
  - A tentative write pointer advances on each written beat. A committed pointer copies the tentative pointer on the TLAST beat.
  - Each commit increments a per-input packet count.
- **Overflow**
  - Overflow occurs if a beat arrives while the FIFO holds `FIFO_DEPTH` words.
  - On overflow the tentative pointer rewinds to the committed pointer and the drop count increments (saturating at 16'hFFFF).
  - The write side then enters DISCARD, ignoring beats through and including the next TLAST.
  - A packet longer than `FIFO_DEPTH` is therefore always dropped.
- **Single-beat packets** (TVALID and TLAST in the same cycle) are legal and commit immediately.
- **Arbiter FSM**
  - States: IDLE, SEND0, SEND1. A round-robin register `last` holds the index last served; its reset value is 1, so input 0 wins the first tie.
  - IDLE → SENDx when count[x] > 0. If both counts are non-zero, grant the input ≠ `last`.
  - SENDx → IDLE on the beat where `mTVALID && mTREADY && mTLAST`. That beat also sets `last` = x and decrements count[x].
  - There is no back-to-back grant without passing through IDLE.
- **Output data path**
  - `mTDATA`/`mTLAST` present the head word of the granted FIFO.
  - The data path is first-word-fall-through via a one-word output register refilled from block RAM. `mTVALID` stays high throughout SENDx when `mTREADY` is held high.
  - `mSource` = x during SENDx.
- **Flush**, on `auroraFAstrobe` or `!auroraResetN`:
  - All pointers and counts go to 0, the FSM goes to IDLE, and `mTVALID` goes to 0.
  - A write side that was mid-packet (tentative ≠ committed, or in DISCARD) enters DISCARD; otherwise it enters IDLE.
  - The beat coincident with the strobe is discarded.
- **Drop counts and `last`** clear only on reset; `auroraFAstrobe` does not clear them.
- **Reset values:** `mTVALID`=0, `mTLAST`=0, `mTDATA`=0, `mSource`=0, drop counts=0, write sides IDLE, not DISCARD.

## Timing
- TLAST beat written in cycle N → count visible in N+1 → grant registered in N+1 → `mTVALID`=1 with the header word in N+2.
- Throughput is one word per cycle while `mTREADY`=1. Inter-packet gap is 1 cycle (the IDLE state).
- `mTVALID`, `mTDATA` and `mTLAST` are stable while `mTVALID && !mTREADY`.
- A commit and a final-word read on the same input in the same cycle leave the count unchanged.
- Full is computed from the read pointer versus the tentative pointer, using pointers with an extra MSB. The read pointer frees space in the cycle after the beat is accepted.

## Structure
- Package `cell_link_pkg` holds:
  - `CELL_LINK_DATA_WIDTH` = 32;
  - the FSM state encoding;
  - `DROP_COUNT_WIDTH` = 16.
- Sub-module `cell_link_packet_fifo` contains:
  - the simple dual-port RAM;
  - tentative, committed and read pointers;
  - the packet count, the DISCARD state and the drop counter.
- `cell_link_packet_fifo` is instantiated twice. The top holds only the arbiter FSM and output mux.

## Test plan
- **Single packet.** 4-word packet on s1 (header 32'hA5BE0400) with `mTREADY`=1 → output header in cycle N+2, 4 contiguous words, `mTLAST` on word 4, `mSource`=1.
- **Tie after reset.** 3-word packets completing on s0 and s1 in the same cycle → s0 packet first, then 1 idle cycle, then s1 packet. Repeat → s1 first.
- **Overflow.** `FIFO_DEPTH`=16, `mTREADY`=0, 20-word packet on s0 → no output, `s0DropCount`=1. A following 2-word packet → delivered intact once `mTREADY`=1.
- **Backpressure.** `mTREADY` toggling 1,0,0,1 during a 5-word packet → data and `mTLAST` held stable while stalled, no word lost or duplicated.
- **FA strobe mid-packet.** Strobe at word 2 of a 6-word s0 packet, with a committed s1 packet pending → `mTVALID`=0 the next cycle, remaining s0 words discarded, the s1 packet never emitted. The next s0 packet is forwarded normally.
- **Reset.** `auroraResetN`=0 during SEND0 → next cycle `mTVALID`=0 and both drop counts = 0.
